// File: rtl/sobel_sequencer_pkg.sv
// rtl/sobel_sequencer_pkg.sv - shared constants, state encoding and helpers for the Sobel sequencer
package sobel_sequencer_pkg;

  localparam int NUM_SOBEL_ACCELERATORS = 16;
  localparam int PERF_W                 = 32;
  localparam int LOADED_W               = 2;

  localparam logic [LOADED_W-1:0] ROWS_NEEDED = LOADED_W'(3);

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_READ  = 3'd1,
    SEQ_WAIT  = 3'd2,
    SEQ_WRITE = 3'd3,
    SEQ_DONE  = 3'd4
  } seq_state_t;

  // Rows held in the three-row stack, saturating once the window is primed.
  function automatic logic [LOADED_W-1:0] loaded_inc(input logic [LOADED_W-1:0] loaded);
    return (loaded == ROWS_NEEDED) ? ROWS_NEEDED : loaded + LOADED_W'(1);
  endfunction

endpackage

// File: rtl/sobel_seq_addr_gen.sv
// rtl/sobel_seq_addr_gen.sv - strip column, source row base and destination row accumulators
// Produces next-cycle read/write addresses and the write byte-enable mask for the active strip.
module sobel_seq_addr_gen
  import sobel_sequencer_pkg::*;
#(
  parameter int N      = NUM_SOBEL_ACCELERATORS,
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_init,
  input  logic              i_shift,
  input  logic              i_next_strip,
  input  logic [DIM_W-1:0]  i_width,
  input  logic [ADDR_W-1:0] i_src_base,
  input  logic [ADDR_W-1:0] i_dst_base,
  output logic [ADDR_W-1:0] o_rd_addr_nxt,
  output logic [ADDR_W-1:0] o_wr_addr_nxt,
  output logic [N-1:0]      o_wr_be_nxt,
  output logic              o_last_strip
);

  localparam logic [DIM_W:0] N_EXT = (DIM_W+1)'(N);

  logic [DIM_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_dst_row;
  logic [DIM_W-1:0]  w_col_nxt;
  logic [ADDR_W-1:0] w_row_base_nxt;
  logic [ADDR_W-1:0] w_dst_row_nxt;
  logic [ADDR_W-1:0] w_width_a;
  logic [ADDR_W-1:0] w_col_a;
  logic [ADDR_W-1:0] w_dst_start;
  logic [DIM_W:0]    w_lim;

  assign w_width_a   = ADDR_W'(i_width);
  // dst_row tracks dst + (row-2)*width, so it starts two rows "above" the base.
  assign w_dst_start = i_dst_base - (w_width_a << 1);
  assign w_lim       = {1'b0, i_width} - (DIM_W+1)'(2);

  always_comb begin
    w_col_nxt      = r_col;
    w_row_base_nxt = r_row_base;
    w_dst_row_nxt  = r_dst_row;
    if (i_init) begin
      w_col_nxt      = '0;
      w_row_base_nxt = i_src_base;
      w_dst_row_nxt  = w_dst_start;
    end else if (i_next_strip) begin
      w_col_nxt      = r_col + DIM_W'(N);
      w_row_base_nxt = i_src_base;
      w_dst_row_nxt  = w_dst_start;
    end else if (i_shift) begin
      w_row_base_nxt = r_row_base + w_width_a;
      w_dst_row_nxt  = r_dst_row + w_width_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_row_base <= '0;
      r_dst_row  <= '0;
    end else begin
      r_col      <= w_col_nxt;
      r_row_base <= w_row_base_nxt;
      r_dst_row  <= w_dst_row_nxt;
    end
  end

  assign w_col_a       = ADDR_W'(w_col_nxt);
  assign o_rd_addr_nxt = w_row_base_nxt + w_col_a;
  assign o_wr_addr_nxt = w_dst_row_nxt + w_col_a + ADDR_W'(1);

  always_comb begin
    o_wr_be_nxt = '0;
    for (int i = 0; i < N; i++) begin
      o_wr_be_nxt[i] = (({1'b0, w_col_nxt} + (DIM_W+1)'(i + 1)) <= w_lim);
    end
  end

  assign o_last_strip = (({1'b0, r_col} + N_EXT) >= w_lim);

endmodule

// File: rtl/sobel_sequencer.sv
// rtl/sobel_sequencer.sv - strip-walking controller feeding the Sobel row registers and output writes
// Optional SOBEL_SEQ_PERF_EN adds busy-cycle and stall counters.
module sobel_sequencer
  import sobel_sequencer_pkg::*;
#(
  parameter int N      = NUM_SOBEL_ACCELERATORS,
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [ADDR_W-1:0] cfg_src_base,
  input  logic [ADDR_W-1:0] cfg_dst_base,
  output logic              busy,
  output logic              done,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_valid,
  output logic              srow_shift,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [N-1:0]      wr_be,
  input  logic              wr_ack
`ifdef SOBEL_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_cycles,
  output logic [PERF_W-1:0] perf_stall
`endif
);

  seq_state_t r_state;
  seq_state_t w_state_nxt;

  logic [DIM_W-1:0]    r_row;
  logic [LOADED_W-1:0] r_loaded;
  logic                r_rd_req;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_wr_req;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [N-1:0]        r_wr_be;

  logic                w_init;
  logic                w_shift;
  logic                w_next_strip;
  logic                w_go_accept;
  logic                w_too_small;
  logic [LOADED_W-1:0] w_loaded_inc;
  logic [ADDR_W-1:0]   w_rd_addr_nxt;
  logic [ADDR_W-1:0]   w_wr_addr_nxt;
  logic [N-1:0]        w_wr_be_nxt;
  logic                w_last_strip;

  assign w_go_accept  = (r_state == SEQ_IDLE) && go;
  assign w_too_small  = (cfg_width < DIM_W'(3)) || (cfg_height < DIM_W'(3));
  assign w_loaded_inc = loaded_inc(r_loaded);

  always_comb begin
    w_state_nxt  = r_state;
    w_init       = 1'b0;
    w_shift      = 1'b0;
    w_next_strip = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        if (go) begin
          if (w_too_small) begin
            w_state_nxt = SEQ_DONE;
          end else begin
            w_init      = 1'b1;
            w_state_nxt = SEQ_READ;
          end
        end
      end
      SEQ_READ: begin
        if (rd_ack) w_state_nxt = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        if (rd_valid) begin
          w_shift     = 1'b1;
          w_state_nxt = (w_loaded_inc == ROWS_NEEDED) ? SEQ_WRITE : SEQ_READ;
        end
      end
      SEQ_WRITE: begin
        if (wr_ack) begin
          if (r_row < cfg_height) begin
            w_state_nxt = SEQ_READ;
          end else if (w_last_strip) begin
            w_state_nxt = SEQ_DONE;
          end else begin
            w_next_strip = 1'b1;
            w_state_nxt  = SEQ_READ;
          end
        end
      end
      SEQ_DONE: w_state_nxt = SEQ_IDLE;
      default:  w_state_nxt = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row    <= '0;
      r_loaded <= '0;
    end else if (w_init || w_next_strip) begin
      r_row    <= '0;
      r_loaded <= '0;
    end else if (w_shift) begin
      r_row    <= r_row + DIM_W'(1);
      r_loaded <= w_loaded_inc;
    end
  end

  sobel_seq_addr_gen #(
    .N      (N),
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_init        (w_init),
    .i_shift       (w_shift),
    .i_next_strip  (w_next_strip),
    .i_width       (cfg_width),
    .i_src_base    (cfg_src_base),
    .i_dst_base    (cfg_dst_base),
    .o_rd_addr_nxt (w_rd_addr_nxt),
    .o_wr_addr_nxt (w_wr_addr_nxt),
    .o_wr_be_nxt   (w_wr_be_nxt),
    .o_last_strip  (w_last_strip)
  );

  // Requests are registered from the next state so acks never reach them combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_req  <= 1'b0;
      r_rd_addr <= '0;
      r_wr_req  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_be   <= '0;
    end else begin
      r_rd_req <= (w_state_nxt == SEQ_READ);
      r_wr_req <= (w_state_nxt == SEQ_WRITE);
      if (w_state_nxt == SEQ_READ) r_rd_addr <= w_rd_addr_nxt;
      if (w_state_nxt == SEQ_WRITE) begin
        r_wr_addr <= w_wr_addr_nxt;
        r_wr_be   <= w_wr_be_nxt;
      end
    end
  end

  assign busy       = (r_state == SEQ_READ) || (r_state == SEQ_WAIT) || (r_state == SEQ_WRITE);
  assign done       = (r_state == SEQ_DONE);
  assign srow_shift = w_shift;
  assign rd_req     = r_rd_req;
  assign rd_addr    = r_rd_addr;
  assign wr_req     = r_wr_req;
  assign wr_addr    = r_wr_addr;
  assign wr_be      = r_wr_be;

`ifdef SOBEL_SEQ_PERF_EN
  logic [PERF_W-1:0] r_perf_cycles;
  logic [PERF_W-1:0] r_perf_stall;
  logic              w_stall;

  assign w_stall = ((r_state == SEQ_READ) && !rd_ack) || ((r_state == SEQ_WRITE) && !wr_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else if (w_go_accept) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (busy && (r_perf_cycles != '1)) r_perf_cycles <= r_perf_cycles + PERF_W'(1);
      if (w_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + PERF_W'(1);
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_stall  = r_perf_stall;
`else
  logic w_unused_go_accept;
  assign w_unused_go_accept = w_go_accept;
`endif

endmodule
